// File: rtl/ddr_wr_pkg.sv
// Shared definitions for the DDR write scheduler: FSM state codes, DDR command
// code and the lane geometry used when packing 12-bit samples into a DDR word.
package ddr_wr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_NEXT  = 2'd3;

  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

  localparam int LANE_W     = 16;
  localparam int SAMPLE_W   = 12;
  localparam int DDR_DATA_W = 128;
  localparam int TOTAL_W    = 25;

  // A sample sits in the low bits of its lane; the spare upper bits stay zero.
  function automatic logic [LANE_W-1:0] pad_sample(input logic [SAMPLE_W-1:0] sample);
    return {{(LANE_W - SAMPLE_W){1'b0}}, sample};
  endfunction

endpackage

// File: rtl/word_packer.sv
// Collects samples into consecutive 16-bit lanes of one DDR word. Sample k of
// the word lands in lane k; lanes never written since the last clear read zero.
module word_packer
  import ddr_wr_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_clear,
  input  logic                    I_valid,
  input  logic [SAMPLE_W-1:0]     I_sample,
  output logic [LANES*LANE_W-1:0] O_data,
  output logic [CNT_W-1:0]        O_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge I_clk) begin
    if (I_rst || I_clear) begin
      r_count <= '0;
    end else if (I_valid && (r_count < CNT_W'(LANES))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] r_lane;

      always_ff @(posedge I_clk) begin
        if (I_rst || I_clear) begin
          r_lane <= '0;
        end else if (I_valid && (r_count == CNT_W'(gi))) begin
          r_lane <= pad_sample(I_sample);
        end
      end

      assign O_data[gi*LANE_W +: LANE_W] = r_lane;
    end
  endgenerate

  assign O_count = r_count;

endmodule

// File: rtl/ddr_wr_scheduler.sv
// Drains a 12-bit sample FIFO into 128-bit DDR words and issues one write per
// word, wrapping the address back to the base when it reaches the limit.
module ddr_wr_scheduler
  import ddr_wr_pkg::*;
#(
  parameter int ADDR_W           = 28,
  parameter int SAMPLES_PER_WORD = 8,
  parameter int ADDR_STEP        = 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_start,
  input  logic [TOTAL_W-1:0]    I_total_points,
  input  logic [ADDR_W-1:0]     I_base_addr,
  input  logic [ADDR_W-1:0]     I_addr_limit,
  input  logic                  I_fifo_empty,
  output logic                  O_fifo_rd_en,
  input  logic [SAMPLE_W-1:0]   I_fifo_data,
  output logic                  O_app_en,
  output logic [2:0]            O_app_cmd,
  output logic [ADDR_W-1:0]     O_app_addr,
  input  logic                  I_app_rdy,
  output logic                  O_app_wdf_wren,
  output logic                  O_app_wdf_end,
  output logic [DDR_DATA_W-1:0] O_app_wdf_data,
  input  logic                  I_app_wdf_rdy,
  output logic                  O_sended_flag,
  output logic                  O_busy,
  output logic                  O_done
);

  localparam int CNT_W  = $clog2(SAMPLES_PER_WORD + 1);
  localparam int PACK_W = SAMPLES_PER_WORD * LANE_W;

  localparam logic [TOTAL_W-1:0] SPW_T = TOTAL_W'(SAMPLES_PER_WORD);
  localparam logic [CNT_W-1:0]   SPW_C = CNT_W'(SAMPLES_PER_WORD);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_base;
  logic [ADDR_W-1:0]    r_limit;
  logic [TOTAL_W-1:0]   r_remaining;
  logic [CNT_W-1:0]     r_target;
  logic [CNT_W-1:0]     r_issued;
  logic                 r_rd_pending;
  logic                 r_app_en;
  logic                 r_wdf_wren;
  logic                 r_sended;
  logic                 r_done;

  logic                 w_rd_en;
  logic                 w_clear;
  logic                 w_start_ok;
  logic                 w_last_capture;
  logic                 w_word_accepted;
  logic [CNT_W-1:0]     w_pack_count;
  logic [PACK_W-1:0]    w_pack_data;
  logic [CNT_W-1:0]     w_start_target;
  logic [CNT_W-1:0]     w_next_target;
  logic [TOTAL_W-1:0]   w_rem_after;
  logic [ADDR_W:0]      w_addr_inc;
  logic [ADDR_W-1:0]    w_addr_next;

  assign w_start_ok     = (r_state == ST_IDLE) && I_start && (I_total_points != '0);
  assign w_start_target = (I_total_points >= SPW_T) ? SPW_C : I_total_points[CNT_W-1:0];
  assign w_rem_after    = r_remaining - TOTAL_W'(r_target);
  assign w_next_target  = (w_rem_after >= SPW_T) ? SPW_C : w_rem_after[CNT_W-1:0];

  // One extra bit keeps the wrap comparison honest near the top of the address space.
  assign w_addr_inc  = {1'b0, r_addr} + (ADDR_W + 1)'(ADDR_STEP);
  assign w_addr_next = (w_addr_inc >= {1'b0, r_limit}) ? r_base : w_addr_inc[ADDR_W-1:0];

  assign w_rd_en = (r_state == ST_FILL) && !I_fifo_empty && (r_issued < r_target);

  // FIFO data follows the read strobe by a cycle, so capture lags issue by one.
  assign w_last_capture = (r_state == ST_FILL) && r_rd_pending
                          && ((w_pack_count + CNT_W'(1)) == r_target);

  assign w_word_accepted = (r_state == ST_WRITE)
                           && (!r_app_en || I_app_rdy)
                           && (!r_wdf_wren || I_app_wdf_rdy);

  assign w_clear = w_start_ok || (r_state == ST_NEXT);

  word_packer #(
    .LANES (SAMPLES_PER_WORD),
    .CNT_W (CNT_W)
  ) u_packer (
    .I_clk    (I_clk),
    .I_rst    (I_rst),
    .I_clear  (w_clear),
    .I_valid  (r_rd_pending),
    .I_sample (I_fifo_data),
    .O_data   (w_pack_data),
    .O_count  (w_pack_count)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_base       <= '0;
      r_limit      <= '0;
      r_remaining  <= '0;
      r_target     <= '0;
      r_issued     <= '0;
      r_rd_pending <= 1'b0;
      r_app_en     <= 1'b0;
      r_wdf_wren   <= 1'b0;
      r_sended     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sended     <= 1'b0;
      r_done       <= 1'b0;
      r_rd_pending <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state     <= ST_FILL;
            r_addr      <= I_base_addr;
            r_base      <= I_base_addr;
            r_limit     <= I_addr_limit;
            r_remaining <= I_total_points;
            r_target    <= w_start_target;
            r_issued    <= '0;
          end else if (I_start) begin
            r_done <= 1'b1;
          end
        end
        ST_FILL: begin
          r_rd_pending <= w_rd_en;
          if (w_rd_en) begin
            r_issued <= r_issued + CNT_W'(1);
          end
          if (w_last_capture) begin
            r_state    <= ST_WRITE;
            r_app_en   <= 1'b1;
            r_wdf_wren <= 1'b1;
          end
        end
        ST_WRITE: begin
          // The command and data channels retire independently of each other.
          if (I_app_rdy) begin
            r_app_en <= 1'b0;
          end
          if (I_app_wdf_rdy) begin
            r_wdf_wren <= 1'b0;
          end
          if (w_word_accepted) begin
            r_sended <= 1'b1;
            r_state  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_remaining <= w_rem_after;
          r_addr      <= w_addr_next;
          r_issued    <= '0;
          if (w_rem_after != '0) begin
            r_state  <= ST_FILL;
            r_target <= w_next_target;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_fifo_rd_en   = w_rd_en;
  assign O_app_en       = r_app_en;
  assign O_app_cmd      = DDR_CMD_WRITE;
  assign O_app_addr     = r_addr;
  assign O_app_wdf_wren = r_wdf_wren;
  assign O_app_wdf_end  = r_wdf_wren;
  assign O_app_wdf_data = DDR_DATA_W'(w_pack_data);
  assign O_sended_flag  = r_sended;
  assign O_busy         = (r_state != ST_IDLE);
  assign O_done         = r_done;

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// Table-driven bench for ddr_wr_scheduler: each vector runs a whole transfer
// against a FIFO/DDR model and compares words, addresses, data and pulses.
module tb_ddr_wr_scheduler;

  logic         I_clk = 1'b0;
  logic         I_rst;
  logic         I_start;
  logic [24:0]  I_total_points;
  logic [27:0]  I_base_addr;
  logic [27:0]  I_addr_limit;
  logic         I_fifo_empty;
  logic         O_fifo_rd_en;
  logic [11:0]  I_fifo_data;
  logic         O_app_en;
  logic [2:0]   O_app_cmd;
  logic [27:0]  O_app_addr;
  logic         I_app_rdy;
  logic         O_app_wdf_wren;
  logic         O_app_wdf_end;
  logic [127:0] O_app_wdf_data;
  logic         I_app_wdf_rdy;
  logic         O_sended_flag;
  logic         O_busy;
  logic         O_done;

  always #5 I_clk = ~I_clk;

  ddr_wr_scheduler dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_start        (I_start),
    .I_total_points (I_total_points),
    .I_base_addr    (I_base_addr),
    .I_addr_limit   (I_addr_limit),
    .I_fifo_empty   (I_fifo_empty),
    .O_fifo_rd_en   (O_fifo_rd_en),
    .I_fifo_data    (I_fifo_data),
    .O_app_en       (O_app_en),
    .O_app_cmd      (O_app_cmd),
    .O_app_addr     (O_app_addr),
    .I_app_rdy      (I_app_rdy),
    .O_app_wdf_wren (O_app_wdf_wren),
    .O_app_wdf_end  (O_app_wdf_end),
    .O_app_wdf_data (O_app_wdf_data),
    .I_app_wdf_rdy  (I_app_wdf_rdy),
    .O_sended_flag  (O_sended_flag),
    .O_busy         (O_busy),
    .O_done         (O_done)
  );

  typedef struct {
    int total;
    int base;
    int limit;
    int delay;
    bit toggle;
    int exp_words;
    int a0;
    int a1;
    int a2;
  } vec_t;

  vec_t vecs[6];

  int checks   = 0;
  int failures = 0;

  // Model state for one transfer.
  int           sample_idx;
  bit           pend_rd;
  int           cyc;
  int           en_wait;
  int           en_cycles;
  int           wren_cycles;
  int           n_cmd;
  int           n_dat;
  int           sended_cnt;
  int           done_cnt;
  int           empty_viol;
  int           stab_viol;
  int           busy_viol;
  bit           prev_en;
  bit           prev_wren;
  logic [27:0]  held_addr;
  logic [127:0] held_data;
  logic [27:0]  rec_addr[8];
  logic [127:0] rec_data[8];

  function automatic logic [11:0] sample_of(input int i);
    int t;
    t = i * 373 + 1445;
    return t[11:0];
  endfunction

  function automatic logic [127:0] exp_word(input int w, input int total);
    logic [127:0] d;
    int idx;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      idx = w * 8 + k;
      if (idx < total) d[16*k +: 16] = {4'b0000, sample_of(idx)};
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    sample_idx = 0; pend_rd = 0; cyc = 0; en_wait = 0;
    en_cycles = 0; wren_cycles = 0; n_cmd = 0; n_dat = 0;
    sended_cnt = 0; done_cnt = 0; empty_viol = 0; stab_viol = 0; busy_viol = 0;
    prev_en = 0; prev_wren = 0; held_addr = '0; held_data = '0;
    for (int i = 0; i < 8; i++) begin
      rec_addr[i] = '0;
      rec_data[i] = '0;
    end
  endtask

  // One clock of the FIFO/DDR model; entered and left at posedge+1.
  task automatic cycle(input bit toggle, input int delay);
    if (pend_rd) begin
      I_fifo_data = sample_of(sample_idx);
      sample_idx++;
      pend_rd = 0;
    end
    I_fifo_empty  = toggle ? cyc[0] : 1'b0;
    cyc++;
    I_app_rdy     = (en_wait >= delay);
    I_app_wdf_rdy = 1'b1;
    #2;
    if (O_fifo_rd_en) begin
      if (I_fifo_empty) empty_viol++;
      pend_rd = 1;
    end
    if (O_app_en) begin
      en_cycles++;
      if (prev_en && O_app_addr !== held_addr) stab_viol++;
      if (O_app_cmd !== 3'b000) stab_viol++;
      held_addr = O_app_addr;
      if (I_app_rdy) begin
        if (n_cmd < 8) rec_addr[n_cmd] = O_app_addr;
        n_cmd++;
        en_wait = 0;
      end else begin
        en_wait++;
      end
    end
    prev_en = O_app_en;
    if (O_app_wdf_wren) begin
      wren_cycles++;
      if (prev_wren && O_app_wdf_data !== held_data) stab_viol++;
      if (!O_app_wdf_end) stab_viol++;
      held_data = O_app_wdf_data;
      if (I_app_wdf_rdy) begin
        if (n_dat < 8) rec_data[n_dat] = O_app_wdf_data;
        n_dat++;
      end
    end
    prev_wren = O_app_wdf_wren;
    if (O_sended_flag) sended_cnt++;
    if (O_done) begin
      done_cnt++;
      if (O_busy) busy_viol++;
    end
    @(posedge I_clk);
    #1;
  endtask

  task automatic pulse_start(input int total, input int base, input int limit);
    I_total_points = 25'(total);
    I_base_addr    = 28'(base);
    I_addr_limit   = 28'(limit);
    I_start        = 1'b1;
    @(posedge I_clk);
    #1;
    I_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"},  128'(O_fifo_rd_en),   128'(0));
    chk({tag, "_app_en"}, 128'(O_app_en),       128'(0));
    chk({tag, "_addr"},   128'(O_app_addr),     128'(0));
    chk({tag, "_wren"},   128'(O_app_wdf_wren), 128'(0));
    chk({tag, "_end"},    128'(O_app_wdf_end),  128'(0));
    chk({tag, "_data"},   O_app_wdf_data,       128'(0));
    chk({tag, "_sended"}, 128'(O_sended_flag),  128'(0));
    chk({tag, "_busy"},   128'(O_busy),         128'(0));
    chk({tag, "_done"},   128'(O_done),         128'(0));
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   post;
    v = vecs[vi];
    reset_model();
    pulse_start(v.total, v.base, v.limit);
    post = 0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt > 0 && post >= 2) break;
      cycle(v.toggle, v.delay);
      if (done_cnt > 0) post++;
    end
    chk($sformatf("v%0d_done", vi),      128'(done_cnt),    128'(1));
    chk($sformatf("v%0d_cmds", vi),      128'(n_cmd),       128'(v.exp_words));
    chk($sformatf("v%0d_dats", vi),      128'(n_dat),       128'(v.exp_words));
    chk($sformatf("v%0d_sended", vi),    128'(sended_cnt),  128'(v.exp_words));
    chk($sformatf("v%0d_en_cyc", vi),    128'(en_cycles),   128'(v.exp_words * (v.delay + 1)));
    chk($sformatf("v%0d_wren_cyc", vi),  128'(wren_cycles), 128'(v.exp_words));
    chk($sformatf("v%0d_empty_rd", vi),  128'(empty_viol),  128'(0));
    chk($sformatf("v%0d_stable", vi),    128'(stab_viol),   128'(0));
    chk($sformatf("v%0d_busy", vi),      128'(busy_viol),   128'(0));
    chk($sformatf("v%0d_addr0", vi),     128'(rec_addr[0]), 128'(v.a0));
    chk($sformatf("v%0d_data0", vi),     rec_data[0],       exp_word(0, v.total));
    if (v.exp_words > 1) begin
      chk($sformatf("v%0d_addr1", vi),   128'(rec_addr[1]), 128'(v.a1));
      chk($sformatf("v%0d_data1", vi),   rec_data[1],       exp_word(1, v.total));
    end
    if (v.exp_words > 2) begin
      chk($sformatf("v%0d_addr2", vi),   128'(rec_addr[2]), 128'(v.a2));
      chk($sformatf("v%0d_data2", vi),   rec_data[2],       exp_word(2, v.total));
    end
    $display("vec %0d total=%0d base=%0h words=%0d sended=%0d done=%0d",
             vi, v.total, v.base, n_cmd, sended_cnt, done_cnt);
  endtask

  initial begin
    vecs[0] = '{total: 16, base: 'h100, limit: 'h1000, delay: 0, toggle: 0, exp_words: 2, a0: 'h100, a1: 'h108, a2: 0};
    vecs[1] = '{total: 11, base: 'h200, limit: 'h1000, delay: 0, toggle: 0, exp_words: 2, a0: 'h200, a1: 'h208, a2: 0};
    vecs[2] = '{total: 24, base: 'h0,   limit: 'h10,   delay: 0, toggle: 0, exp_words: 3, a0: 'h0,   a1: 'h8,   a2: 'h0};
    vecs[3] = '{total: 8,  base: 'h40,  limit: 'h1000, delay: 3, toggle: 0, exp_words: 1, a0: 'h40,  a1: 0,     a2: 0};
    vecs[4] = '{total: 10, base: 'h300, limit: 'h1000, delay: 0, toggle: 1, exp_words: 2, a0: 'h300, a1: 'h308, a2: 0};
    vecs[5] = '{total: 1,  base: 'hFF8, limit: 'h1000, delay: 2, toggle: 1, exp_words: 1, a0: 'hFF8, a1: 0,     a2: 0};

    I_rst = 1'b1; I_start = 1'b0; I_total_points = '0; I_base_addr = '0;
    I_addr_limit = '0; I_fifo_empty = 1'b1; I_fifo_data = '0;
    I_app_rdy = 1'b0; I_app_wdf_rdy = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    check_outputs_zero("reset");
    I_rst = 1'b0;
    @(posedge I_clk);
    #1;

    // A zero-length start completes immediately without leaving IDLE.
    pulse_start(0, 'h100, 'h1000);
    chk("zero_done",  128'(O_done), 128'(1));
    chk("zero_busy",  128'(O_busy), 128'(0));
    @(posedge I_clk);
    #1;
    chk("zero_done_clr", 128'(O_done), 128'(0));

    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // Reset in the middle of a write abandons the outstanding request.
    reset_model();
    pulse_start(8, 'h500, 'h1000);
    for (int c = 0; c < 60; c++) begin
      if (prev_en) break;
      cycle(1'b0, 1000);
    end
    chk("rst_reached_write", 128'(prev_en), 128'(1));
    I_rst = 1'b1;
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    check_outputs_zero("midrst");
    $display("midwrite reset applied, busy=%0d", O_busy);

    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
